// File: rtl/spring_force_accum.sv
// Sequential spring-force accumulator: walks the spring list, hands each enabled spring to an
// external force engine, accumulates saturated per-node totals and streams them over ready/valid.
module spring_force_accum #(
  parameter int NUM_SPRINGS   = 16,
  parameter int NUM_NODES     = 8,
  parameter int POSITION_SIZE = 16,
  parameter int VELOCITY_SIZE = 16,
  parameter int FORCE_SIZE    = 24,
  localparam int NIDX = $clog2(NUM_NODES) + 1
) (
  input  logic                                          clk_in,
  input  logic                                          rst_in_n,
  input  logic                                          start_in,
  input  logic [NUM_SPRINGS-1:0]                        spring_en_in,
  input  logic [1:0][NUM_SPRINGS-1:0][NIDX-1:0]         springs_in,
  input  logic [NUM_SPRINGS-1:0][POSITION_SIZE-1:0]     equilibriums_in,
  input  logic [1:0][NUM_NODES-1:0][POSITION_SIZE-1:0]  nodes_in,
  input  logic [1:0][NUM_NODES-1:0][VELOCITY_SIZE-1:0]  velocities_in,
  output logic                                          eng_req_out,
  output logic [1:0][POSITION_SIZE-1:0]                 eng_v1_out,
  output logic [1:0][POSITION_SIZE-1:0]                 eng_v2_out,
  output logic [1:0][VELOCITY_SIZE-1:0]                 eng_vel1_out,
  output logic [1:0][VELOCITY_SIZE-1:0]                 eng_vel2_out,
  output logic [POSITION_SIZE-1:0]                      eng_eq_out,
  input  logic                                          eng_done_in,
  input  logic signed [FORCE_SIZE-1:0]                  eng_fx_in,
  input  logic signed [FORCE_SIZE-1:0]                  eng_fy_in,
  output logic                                          force_valid_out,
  input  logic                                          force_ready_in,
  output logic signed [FORCE_SIZE-1:0]                  force_x_out,
  output logic signed [FORCE_SIZE-1:0]                  force_y_out,
  output logic [NIDX-1:0]                               force_node_out,
  output logic                                          force_last_out,
  output logic                                          busy_out,
  output logic                                          done_out,
  output logic                                          sat_out,
  output logic                                          bad_idx_out
);

  localparam int SPW = $clog2(NUM_SPRINGS + 1);
  localparam int SIW = (NUM_SPRINGS > 1) ? $clog2(NUM_SPRINGS) : 1;
  localparam int NPW = NIDX - 1;

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_WAIT, S_STREAM} state_t;

  state_t                       state;
  logic [SPW-1:0]               spr_ptr;
  logic [NPW-1:0]               node_ptr;
  logic [NPW-1:0]               cur_n1, cur_n2;
  logic signed [FORCE_SIZE-1:0] acc_x [NUM_NODES];
  logic signed [FORCE_SIZE-1:0] acc_y [NUM_NODES];
  logic signed [FORCE_SIZE-1:0] nxt_x [NUM_NODES];
  logic signed [FORCE_SIZE-1:0] nxt_y [NUM_NODES];
  logic                         upd_sat;
  logic signed [FORCE_SIZE:0]   fx_w, fy_w, sx, sy;
  logic [SIW-1:0]               sidx;
  logic [NIDX-1:0]              sn1, sn2;
  logic                         idx_bad;
  logic [NPW-1:0]               nn;

  function automatic logic signed [FORCE_SIZE-1:0] sat_f(input logic signed [FORCE_SIZE:0] v);
    if (v[FORCE_SIZE] != v[FORCE_SIZE-1])
      sat_f = v[FORCE_SIZE] ? {1'b1, {(FORCE_SIZE-1){1'b0}}} : {1'b0, {(FORCE_SIZE-1){1'b1}}};
    else
      sat_f = v[FORCE_SIZE-1:0];
  endfunction

  function automatic logic ovf_f(input logic signed [FORCE_SIZE:0] v);
    return v[FORCE_SIZE] != v[FORCE_SIZE-1];
  endfunction

  assign sidx    = spr_ptr[SIW-1:0];
  assign sn1     = springs_in[0][sidx];
  assign sn2     = springs_in[1][sidx];
  assign idx_bad = (sn1 >= NIDX'(NUM_NODES)) || (sn2 >= NIDX'(NUM_NODES));
  assign nn      = node_ptr + NPW'(1);

  // Per-node update for the spring in flight; a self-loop spring nets to zero, not last-write-wins.
  always_comb begin
    fx_w    = {eng_fx_in[FORCE_SIZE-1], eng_fx_in};
    fy_w    = {eng_fy_in[FORCE_SIZE-1], eng_fy_in};
    upd_sat = 1'b0;
    sx      = '0;
    sy      = '0;
    for (int i = 0; i < NUM_NODES; i++) begin
      sx = {acc_x[i][FORCE_SIZE-1], acc_x[i]};
      sy = {acc_y[i][FORCE_SIZE-1], acc_y[i]};
      if (cur_n2 == NPW'(i) && cur_n1 != NPW'(i)) begin
        sx = sx + fx_w;
        sy = sy + fy_w;
      end else if (cur_n1 == NPW'(i) && cur_n2 != NPW'(i)) begin
        sx = sx - fx_w;
        sy = sy - fy_w;
      end
      nxt_x[i] = sat_f(sx);
      nxt_y[i] = sat_f(sy);
      upd_sat  = upd_sat | ovf_f(sx) | ovf_f(sy);
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in_n) begin
      state           <= S_IDLE;
      spr_ptr         <= '0;
      node_ptr        <= '0;
      cur_n1          <= '0;
      cur_n2          <= '0;
      for (int i = 0; i < NUM_NODES; i++) begin
        acc_x[i] <= '0;
        acc_y[i] <= '0;
      end
      eng_req_out     <= 1'b0;
      eng_v1_out      <= '0;
      eng_v2_out      <= '0;
      eng_vel1_out    <= '0;
      eng_vel2_out    <= '0;
      eng_eq_out      <= '0;
      force_valid_out <= 1'b0;
      force_x_out     <= '0;
      force_y_out     <= '0;
      force_node_out  <= '0;
      force_last_out  <= 1'b0;
      busy_out        <= 1'b0;
      done_out        <= 1'b0;
      sat_out         <= 1'b0;
      bad_idx_out     <= 1'b0;
    end else begin
      eng_req_out <= 1'b0;
      done_out    <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start_in) begin
            for (int i = 0; i < NUM_NODES; i++) begin
              acc_x[i] <= '0;
              acc_y[i] <= '0;
            end
            spr_ptr     <= '0;
            sat_out     <= 1'b0;
            bad_idx_out <= 1'b0;
            busy_out    <= 1'b1;
            state       <= S_SCAN;
          end
        end
        S_SCAN: begin
          if (spr_ptr == SPW'(NUM_SPRINGS)) begin
            node_ptr        <= '0;
            force_valid_out <= 1'b1;
            force_node_out  <= '0;
            force_x_out     <= acc_x[0];
            force_y_out     <= acc_y[0];
            force_last_out  <= 1'b0;
            state           <= S_STREAM;
          end else if (!spring_en_in[sidx]) begin
            spr_ptr <= spr_ptr + SPW'(1);
          end else if (idx_bad) begin
            bad_idx_out <= 1'b1;
            spr_ptr     <= spr_ptr + SPW'(1);
          end else begin
            eng_v1_out[0]   <= nodes_in[0][sn1[NPW-1:0]];
            eng_v1_out[1]   <= nodes_in[1][sn1[NPW-1:0]];
            eng_v2_out[0]   <= nodes_in[0][sn2[NPW-1:0]];
            eng_v2_out[1]   <= nodes_in[1][sn2[NPW-1:0]];
            eng_vel1_out[0] <= velocities_in[0][sn1[NPW-1:0]];
            eng_vel1_out[1] <= velocities_in[1][sn1[NPW-1:0]];
            eng_vel2_out[0] <= velocities_in[0][sn2[NPW-1:0]];
            eng_vel2_out[1] <= velocities_in[1][sn2[NPW-1:0]];
            eng_eq_out      <= equilibriums_in[sidx];
            cur_n1          <= sn1[NPW-1:0];
            cur_n2          <= sn2[NPW-1:0];
            eng_req_out     <= 1'b1;
            state           <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (eng_done_in) begin
            for (int i = 0; i < NUM_NODES; i++) begin
              acc_x[i] <= nxt_x[i];
              acc_y[i] <= nxt_y[i];
            end
            sat_out <= sat_out | upd_sat;
            spr_ptr <= spr_ptr + SPW'(1);
            state   <= S_SCAN;
          end
        end
        S_STREAM: begin
          if (force_ready_in) begin
            if (node_ptr == NPW'(NUM_NODES - 1)) begin
              force_valid_out <= 1'b0;
              force_last_out  <= 1'b0;
              busy_out        <= 1'b0;
              done_out        <= 1'b1;
              state           <= S_IDLE;
            end else begin
              node_ptr       <= nn;
              force_node_out <= {1'b0, nn};
              force_x_out    <= acc_x[nn];
              force_y_out    <= acc_y[nn];
              force_last_out <= (nn == NPW'(NUM_NODES - 1));
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spring_force_accum.sv
// Directed bench for spring_force_accum: engine model, per-node scoreboard, reset and backpressure cases.
module tb_spring_force_accum;
  localparam int S = 16;
  localparam int N = 8;
  localparam int PS = 16;
  localparam int VS = 16;
  localparam int FS = 24;
  localparam int NIDX = $clog2(N) + 1;
  localparam longint FMAX = (longint'(1) << (FS - 1)) - 1;
  localparam longint FMIN = -(longint'(1) << (FS - 1));

  typedef struct {
    logic [NIDX-1:0] node;
    logic [FS-1:0]   x, y;
    logic            last;
  } exp_t;

  typedef struct {
    int            s, n1, n2;
    logic [FS-1:0] fx, fy;
  } op_t;

  logic clk_in, rst_in_n, start_in;
  logic [S-1:0] en;
  logic [1:0][S-1:0][NIDX-1:0] spr;
  logic [S-1:0][PS-1:0] eqs;
  logic [1:0][N-1:0][PS-1:0] nod;
  logic [1:0][N-1:0][VS-1:0] vel;
  logic eng_req_out, eng_done_in;
  logic [1:0][PS-1:0] eng_v1_out, eng_v2_out;
  logic [1:0][VS-1:0] eng_vel1_out, eng_vel2_out;
  logic [PS-1:0] eng_eq_out;
  logic signed [FS-1:0] eng_fx_in, eng_fy_in, force_x_out, force_y_out;
  logic force_valid_out, force_ready_in, force_last_out;
  logic [NIDX-1:0] force_node_out;
  logic busy_out, done_out, sat_out, bad_idx_out;

  longint tfx[S], tfy[S];
  exp_t exp_q[$];
  op_t op_q[$];
  op_t cur;
  int pend, eng_reqs, exp_reqs, first_eng;
  bit exp_sat, exp_bad, eng_mute;
  int checks = 0;
  int failures = 0;

  spring_force_accum #(.NUM_SPRINGS(S), .NUM_NODES(N), .POSITION_SIZE(PS),
                       .VELOCITY_SIZE(VS), .FORCE_SIZE(FS)) dut (
    .clk_in(clk_in), .rst_in_n(rst_in_n), .start_in(start_in),
    .spring_en_in(en), .springs_in(spr), .equilibriums_in(eqs),
    .nodes_in(nod), .velocities_in(vel),
    .eng_req_out(eng_req_out), .eng_v1_out(eng_v1_out), .eng_v2_out(eng_v2_out),
    .eng_vel1_out(eng_vel1_out), .eng_vel2_out(eng_vel2_out), .eng_eq_out(eng_eq_out),
    .eng_done_in(eng_done_in), .eng_fx_in(eng_fx_in), .eng_fy_in(eng_fy_in),
    .force_valid_out(force_valid_out), .force_ready_in(force_ready_in),
    .force_x_out(force_x_out), .force_y_out(force_y_out),
    .force_node_out(force_node_out), .force_last_out(force_last_out),
    .busy_out(busy_out), .done_out(done_out), .sat_out(sat_out), .bad_idx_out(bad_idx_out)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    check(tag, {busy_out, done_out, force_valid_out, eng_req_out, sat_out, bad_idx_out,
                force_last_out, force_node_out, force_x_out, force_y_out, eng_eq_out,
                eng_v1_out, eng_vel2_out}, '0);
  endtask

  function automatic longint clampv(input longint v, inout bit s);
    if (v > FMAX) begin s = 1'b1; return FMAX; end
    if (v < FMIN) begin s = 1'b1; return FMIN; end
    return v;
  endfunction

  // Force engine: answers each request after a random delay, checking the operands it was given.
  initial begin
    eng_done_in = 1'b0; eng_fx_in = '0; eng_fy_in = '0; pend = -1; eng_reqs = 0;
    forever begin
      @(posedge clk_in); #1;
      eng_done_in = 1'b0;
      if (eng_mute) pend = -1;
      else begin
        if (pend < 0 && eng_req_out) begin
          eng_reqs++;
          check("eng_op_avail", op_q.size() != 0, 1'b1);
          if (op_q.size() != 0) begin
            cur = op_q.pop_front();
            pend = $urandom_range(0, 3);
          end
        end
        if (pend == 0) begin
          check("eng_operands", {eng_v1_out, eng_v2_out, eng_vel1_out, eng_vel2_out, eng_eq_out},
                {nod[1][cur.n1], nod[0][cur.n1], nod[1][cur.n2], nod[0][cur.n2],
                 vel[1][cur.n1], vel[0][cur.n1], vel[1][cur.n2], vel[0][cur.n2], eqs[cur.s]});
          eng_fx_in = cur.fx; eng_fy_in = cur.fy; eng_done_in = 1'b1; pend = -1;
        end else if (pend > 0) pend--;
      end
    end
  end

  task automatic clear_springs();
    en = '0; spr = '0;
    for (int s = 0; s < S; s++) begin tfx[s] = 0; tfy[s] = 0; end
  endtask

  task automatic set_spring(input int s, input int a, input int b, input longint fx, input longint fy);
    en[s] = 1'b1; spr[0][s] = NIDX'(a); spr[1][s] = NIDX'(b); tfx[s] = fx; tfy[s] = fy;
  endtask

  task automatic build();
    longint ax[N], ay[N];
    op_t o;
    exp_t e;
    exp_sat = 0; exp_bad = 0; exp_reqs = 0; first_eng = -1; eng_reqs = 0;
    op_q.delete(); exp_q.delete();
    for (int i = 0; i < N; i++) begin ax[i] = 0; ay[i] = 0; end
    for (int s = 0; s < S; s++) begin
      if (!en[s]) continue;
      if (int'(spr[0][s]) >= N || int'(spr[1][s]) >= N) begin exp_bad = 1; continue; end
      if (first_eng < 0) first_eng = s;
      exp_reqs++;
      o.s = s; o.n1 = int'(spr[0][s]); o.n2 = int'(spr[1][s]);
      o.fx = tfx[s][FS-1:0]; o.fy = tfy[s][FS-1:0];
      op_q.push_back(o);
      if (o.n1 != o.n2) begin
        ax[o.n1] = clampv(ax[o.n1] - tfx[s], exp_sat);
        ay[o.n1] = clampv(ay[o.n1] - tfy[s], exp_sat);
        ax[o.n2] = clampv(ax[o.n2] + tfx[s], exp_sat);
        ay[o.n2] = clampv(ay[o.n2] + tfy[s], exp_sat);
      end
    end
    for (int i = 0; i < N; i++) begin
      e.node = NIDX'(i); e.x = ax[i][FS-1:0]; e.y = ay[i][FS-1:0]; e.last = (i == N - 1);
      exp_q.push_back(e);
    end
  endtask

  task automatic do_start();
    int n;
    start_in = 1'b1;
    @(posedge clk_in); #1;
    start_in = 1'b0;
    check("busy_after_start", busy_out, 1'b1);
    if (first_eng >= 0) begin
      n = 1;
      while (!eng_req_out && n < 200) begin @(posedge clk_in); #1; n++; end
      check("req_latency", n, 2 + first_eng);
    end
  endtask

  task automatic drain(input int mode);
    int cyc;
    bit stall, fin, rdy;
    exp_t e;
    logic [NIDX+2*FS-1:0] held;
    cyc = 0; stall = 0; fin = 0;
    while (!fin && cyc < 3000) begin
      @(posedge clk_in); #1; cyc++;
      if (stall) begin
        check("stall_hold", {force_valid_out, force_node_out, force_x_out, force_y_out}, {1'b1, held});
        stall = 0;
      end
      if (force_valid_out) begin
        rdy = (mode == 0) ? 1'b1 : (mode == 1) ? cyc[0] : 1'($urandom_range(0, 1));
        force_ready_in = rdy;
        if (rdy) begin
          check("stream_extra", exp_q.size() != 0, 1'b1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("node", force_node_out, e.node);
            check("force_x", {force_x_out}, e.x);
            check("force_y", {force_y_out}, e.y);
            check("last", force_last_out, e.last);
            fin = e.last;
          end
        end else begin
          stall = 1; held = {force_node_out, force_x_out, force_y_out};
        end
      end else force_ready_in = 1'b0;
    end
    check("stream_complete", fin, 1'b1);
    if (fin) begin
      @(posedge clk_in); #1;
      force_ready_in = 1'b0;
      check("done_pulse", {done_out, busy_out, force_valid_out}, 3'b100);
      @(posedge clk_in); #1;
      check("done_clear", done_out, 1'b0);
    end else force_ready_in = 1'b0;
  endtask

  task automatic run_pass(input int mode);
    build();
    do_start();
    drain(mode);
    check("sat_flag", sat_out, exp_sat);
    check("bad_flag", bad_idx_out, exp_bad);
    check("req_count", eng_reqs, exp_reqs);
  endtask

  task automatic reset_pulse(input string tag);
    rst_in_n = 1'b0;
    @(posedge clk_in); #1;
    check_zero(tag);
    rst_in_n = 1'b1;
    op_q.delete(); exp_q.delete();
  endtask

  initial begin
    int n;
    rst_in_n = 1'b0; start_in = 1'b0; force_ready_in = 1'b0; eng_mute = 1'b0;
    for (int i = 0; i < N; i++) begin
      nod[0][i] = PS'(100 * i + 1); nod[1][i] = PS'(-7 * i - 3);
      vel[0][i] = VS'(3 * i);       vel[1][i] = VS'(i + 40);
    end
    for (int s = 0; s < S; s++) eqs[s] = PS'(1000 + s);
    clear_springs();
    repeat (3) @(posedge clk_in); #1;
    check_zero("reset_outputs");
    rst_in_n = 1'b1;
    @(posedge clk_in); #1;
    check("idle_busy", busy_out, 1'b0);

    clear_springs(); set_spring(0, 0, 1, 100, -50); run_pass(0);
    clear_springs(); set_spring(1, 0, 2, 10, 0); set_spring(2, 1, 2, 10, 0);
    set_spring(3, 2, 3, 10, 0); run_pass(1);
    clear_springs(); set_spring(0, 3, 3, 500, 500); run_pass(0);
    clear_springs(); run_pass(2);
    clear_springs(); set_spring(0, 0, 1, 4194304, -4194304);
    set_spring(1, 0, 1, 4194304, -4194304); run_pass(0);
    clear_springs(); set_spring(0, 0, 9, 77, 77); set_spring(1, 2, 5, 33, -44);
    set_spring(4, 6, 7, -5, 12); set_spring(5, 9, 1, 1, 1); set_spring(9, 5, 0, -20, 20);
    run_pass(1);
    clear_springs();
    for (int s = 0; s < S; s++)
      set_spring(s, $urandom_range(0, N - 1), $urandom_range(0, N - 1),
                 longint'($urandom_range(0, 2000)) - 1000, longint'($urandom_range(0, 2000)) - 1000);
    run_pass(2);

    // Reset while the engine is outstanding, then a clean pass.
    clear_springs(); set_spring(2, 1, 4, 60, -60);
    eng_mute = 1'b1;
    build(); do_start();
    repeat (2) @(posedge clk_in); #1;
    reset_pulse("reset_in_wait");
    eng_mute = 1'b0;
    run_pass(0);

    // Reset while stalled in the output stream, then a clean pass.
    build(); do_start();
    n = 0;
    while (!force_valid_out && n < 300) begin @(posedge clk_in); #1; n++; end
    check("stream_reached", force_valid_out, 1'b1);
    reset_pulse("reset_in_stream");
    run_pass(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
